// File: rtl/vdc_pkg.sv
// Shared constants for the VDC register file: register indices, default
// shadow/external/fill masks and the chip version encoding.
package vdc_pkg;

    localparam int unsigned VDC_NUM_REGS = 38;
    localparam int unsigned VDC_DATA_W   = 8;
    localparam int unsigned VDC_SEL_W    = 6;

    // Register indices with special behaviour
    localparam int unsigned R_LP_V      = 16;
    localparam int unsigned R_LP_H      = 17;
    localparam int unsigned R_VER_GATED = 37;

    typedef enum logic [1:0] {
        VDC_VER_8563_R7A = 2'd0,
        VDC_VER_8563_R8  = 2'd1,
        VDC_VER_8563_R9  = 2'd2,
        VDC_VER_8568     = 2'd3
    } vdc_version_e;

    // Registers 0-9 and 22-25 update on the frame boundary when double-buffered
    localparam logic [63:0] SHADOW_MASK_DEFAULT = 64'h0000_0000_03C0_03FF;
    // Registers 18, 19 and 30-33 live in the external block
    localparam logic [63:0] EXT_MASK_DEFAULT    = 64'h0000_0003_C00C_0000;

    // Unimplemented bits of each register, read back as ones
    function automatic logic [7:0] fill_byte(input int unsigned idx);
        case (idx)
            5, 9, 11, 23, 29: fill_byte = 8'hE0;
            8:                fill_byte = 8'hFC;
            10, 37:           fill_byte = 8'h80;
            28:               fill_byte = 8'h1F;
            36:               fill_byte = 8'hF0;
            default:          fill_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [VDC_NUM_REGS*VDC_DATA_W-1:0] fill_default();
        logic [VDC_NUM_REGS*VDC_DATA_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < VDC_NUM_REGS; i++) begin
            v[i*VDC_DATA_W +: VDC_DATA_W] = fill_byte(i);
        end
        return v;
    endfunction

    localparam logic [VDC_NUM_REGS*VDC_DATA_W-1:0] FILL_MASK_DEFAULT = fill_default();

endpackage

// File: rtl/vdc_lightpen_latch.sv
// Light-pen capture: latches the pen position into R16/R17 on the first
// strobe and holds it until software reads the status register.
module vdc_lightpen_latch #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_strobe,
    input  logic              i_status_rd,
    input  logic [DATA_W-1:0] i_lp_h,
    input  logic [DATA_W-1:0] i_lp_v,
    output logic              o_status,
    output logic [DATA_W-1:0] o_lp_v,
    output logic [DATA_W-1:0] o_lp_h
);

    logic              r_status;
    logic [DATA_W-1:0] r_lp_v;
    logic [DATA_W-1:0] r_lp_h;
    logic              w_capture;

    // A strobe coinciding with the status read that clears the flag still captures
    assign w_capture = i_strobe & (~r_status | i_status_rd);

    // Capture position and set the flag, or clear the flag on a status read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= 1'b0;
            r_lp_v   <= '0;
            r_lp_h   <= '0;
        end else if (w_capture) begin
            r_status <= 1'b1;
            r_lp_v   <= i_lp_v;
            r_lp_h   <= i_lp_h;
        end else if (i_status_rd) begin
            r_status <= 1'b0;
        end
    end

    assign o_status = r_status;
    assign o_lp_v   = r_lp_v;
    assign o_lp_h   = r_lp_h;

endmodule

// File: rtl/vdc_regfile.sv
// VDC indirect register file: address/data port pair, staging and active
// register banks with frame-synchronous shadow updates, external register
// forwarding and a light-pen status latch.
module vdc_regfile
    import vdc_pkg::*;
#(
    parameter int unsigned                  NUM_REGS    = VDC_NUM_REGS,
    parameter int unsigned                  DATA_W      = VDC_DATA_W,
    parameter int unsigned                  SEL_W       = VDC_SEL_W,
    parameter logic [63:0]                  SHADOW_MASK = SHADOW_MASK_DEFAULT,
    parameter logic [63:0]                  EXT_MASK    = EXT_MASK_DEFAULT,
    parameter logic [NUM_REGS*DATA_W-1:0]   FILL_MASK   = FILL_MASK_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enableBus,
    input  logic                       cs,
    input  logic                       rs,
    input  logic                       we,
    input  logic [DATA_W-1:0]          db_in,
    output logic [DATA_W-1:0]          db_out,
    input  logic [1:0]                 version,
    input  logic                       busy,
    input  logic                       vblank,
    input  logic                       frame_start,
    input  logic                       lp_strobe,
    input  logic [DATA_W-1:0]          lp_h,
    input  logic [DATA_W-1:0]          lp_v,
    output logic                       ext_wr,
    output logic [SEL_W-1:0]           ext_sel,
    input  logic [DATA_W-1:0]          ext_rd_data,
    input  logic                       shadow_en,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W+1)'(NUM_REGS);

    logic [SEL_W-1:0]    r_sel;
    logic                r_ext_wr;
    logic [DATA_W-1:0]   r_staging [NUM_REGS];
    logic [DATA_W-1:0]   r_active  [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;

    logic                w_access;
    logic                w_wr_addr;
    logic                w_wr_data;
    logic                w_rd_stat;
    logic                w_rd_data;
    logic                w_sel_valid;
    logic                w_is_ext;
    logic                w_is_shadow;
    logic                w_read_only;
    logic                w_ver_blocked;
    logic                w_wr_ok;
    logic [DATA_W-1:0]   w_sel_stage;
    logic [DATA_W-1:0]   w_sel_fill;
    logic [DATA_W-1:0]   w_rd_val;
    logic [DATA_W-1:0]   w_status;
    logic                w_lp_status;
    logic [DATA_W-1:0]   w_lp_v;
    logic [DATA_W-1:0]   w_lp_h;

    assign w_access  = cs & enableBus;
    assign w_wr_addr = w_access &  we & ~rs;
    assign w_wr_data = w_access &  we &  rs;
    assign w_rd_stat = w_access & ~we & ~rs;
    assign w_rd_data = w_access & ~we &  rs;

    assign w_sel_valid   = {1'b0, r_sel} < NUM_REGS_W;
    assign w_read_only   = (r_sel == SEL_W'(R_LP_V)) || (r_sel == SEL_W'(R_LP_H));
    assign w_ver_blocked = (r_sel == SEL_W'(R_VER_GATED)) &&
                           (version != VDC_VER_8563_R9) && (version != VDC_VER_8568);
    assign w_wr_ok       = w_wr_data & w_sel_valid & ~w_is_ext & ~w_read_only & ~w_ver_blocked;

    // Decode per-register attributes and readback value of the selected register
    always_comb begin
        w_is_ext    = 1'b0;
        w_is_shadow = 1'b0;
        w_sel_stage = '0;
        w_sel_fill  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_is_ext    = EXT_MASK[i];
                w_is_shadow = SHADOW_MASK[i];
                w_sel_fill  = FILL_MASK[i*DATA_W +: DATA_W];
                if (i == R_LP_V)      w_sel_stage = w_lp_v;
                else if (i == R_LP_H) w_sel_stage = w_lp_h;
                else                  w_sel_stage = r_staging[i];
            end
        end
    end

    // Data-port read value: external, out-of-range, or staged value with fill bits
    always_comb begin
        w_rd_val = w_sel_stage | w_sel_fill;
        if (!w_sel_valid)  w_rd_val = '1;
        else if (w_is_ext) w_rd_val = ext_rd_data;
    end

    assign w_status = {~busy, w_lp_status, vblank, {(DATA_W-5){1'b0}}, version};

    vdc_lightpen_latch #(
        .DATA_W (DATA_W)
    ) u_lightpen (
        .clk         (clk),
        .reset       (reset),
        .i_strobe    (lp_strobe),
        .i_status_rd (w_rd_stat),
        .i_lp_h      (lp_h),
        .i_lp_v      (lp_v),
        .o_status    (w_lp_status),
        .o_lp_v      (w_lp_v),
        .o_lp_h      (w_lp_h)
    );

    // Bus address/data handling, read data register and external write strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel    <= '0;
            r_ext_wr <= 1'b0;
            db_out   <= '0;
        end else begin
            r_ext_wr <= w_wr_data & w_sel_valid & w_is_ext;
            if (w_wr_addr) r_sel <= db_in[SEL_W-1:0];
            if (w_rd_stat)      db_out <= w_status;
            else if (w_rd_data) db_out <= w_rd_val;
        end
    end

    // Staging/active banks: a direct write overrides any pending flush of the same register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_staging[i] <= '0;
                r_active[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (r_pending[i] && (frame_start || !shadow_en)) begin
                    r_active[i]  <= r_staging[i];
                    r_pending[i] <= 1'b0;
                end
                if (w_wr_ok && (r_sel == SEL_W'(i))) begin
                    r_staging[i] <= db_in;
                    if (w_is_shadow && shadow_en && !frame_start) begin
                        r_pending[i] <= 1'b1;
                    end else begin
                        r_active[i]  <= db_in;
                        r_pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Expose active registers; light-pen registers come from the capture latch
    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (i == R_LP_V)      reg_q[i*DATA_W +: DATA_W] = w_lp_v;
            else if (i == R_LP_H) reg_q[i*DATA_W +: DATA_W] = w_lp_h;
            else                  reg_q[i*DATA_W +: DATA_W] = r_active[i];
        end
    end

    assign ext_wr  = r_ext_wr;
    assign ext_sel = r_sel;

endmodule

// File: tb/tb_vdc_regfile.sv
// Directed self-checking bench for vdc_regfile with default parameters.
module tb_vdc_regfile;

    logic         clk = 1'b0;
    logic         reset;
    logic         enableBus;
    logic         cs;
    logic         rs;
    logic         we;
    logic [7:0]   db_in;
    logic [7:0]   db_out;
    logic [1:0]   version;
    logic         busy;
    logic         vblank;
    logic         frame_start;
    logic         lp_strobe;
    logic [7:0]   lp_h;
    logic [7:0]   lp_v;
    logic         ext_wr;
    logic [5:0]   ext_sel;
    logic [7:0]   ext_rd_data;
    logic         shadow_en;
    logic [303:0] reg_q;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vdc_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .enableBus   (enableBus),
        .cs          (cs),
        .rs          (rs),
        .we          (we),
        .db_in       (db_in),
        .db_out      (db_out),
        .version     (version),
        .busy        (busy),
        .vblank      (vblank),
        .frame_start (frame_start),
        .lp_strobe   (lp_strobe),
        .lp_h        (lp_h),
        .lp_v        (lp_v),
        .ext_wr      (ext_wr),
        .ext_sel     (ext_sel),
        .ext_rd_data (ext_rd_data),
        .shadow_en   (shadow_en),
        .reg_q       (reg_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rq(input int unsigned n);
        return reg_q[n*8 +: 8];
    endfunction

    task automatic bus(input logic en, input logic r, input logic w, input logic [7:0] d);
        cs = 1'b1; enableBus = en; rs = r; we = w; db_in = d;
        tick();
        cs = 1'b0; enableBus = 1'b0; rs = 1'b0; we = 1'b0; db_in = '0;
    endtask

    task automatic wr(input logic r, input logic [7:0] d);
        bus(1'b1, r, 1'b1, d);
    endtask

    task automatic rd(input logic r);
        bus(1'b1, r, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b1; enableBus = 1'b0; cs = 1'b0; rs = 1'b0; we = 1'b0;
        db_in = '0; version = 2'd0; busy = 1'b0; vblank = 1'b1;
        frame_start = 1'b0; lp_strobe = 1'b0; lp_h = '0; lp_v = '0;
        ext_rd_data = 8'hA5; shadow_en = 1'b0;
        tick(); tick();
        check("reset_db_out", 64'(db_out), 64'h0);
        check("reset_ext_wr", 64'(ext_wr), 64'h0);
        check("reset_reg_q_zero", 64'(reg_q == '0), 64'h1);
        reset = 1'b0;

        // Unshadowed write
        wr(1'b0, 8'd1);
        wr(1'b1, 8'h50);
        check("r1_active", 64'(rq(1)), 64'h50);
        rd(1'b1);
        check("r1_read", 64'(db_out), 64'h50);

        // Shadowed write waits for frame_start
        shadow_en = 1'b1;
        wr(1'b0, 8'd0);
        wr(1'b1, 8'h7F);
        check("r0_held", 64'(rq(0)), 64'h0);
        rd(1'b1);
        check("r0_readback", 64'(db_out), 64'h7F);
        check("r0_still_held", 64'(rq(0)), 64'h0);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("r0_after_frame", 64'(rq(0)), 64'h7F);

        // Write coinciding with frame_start
        wr(1'b0, 8'd6);
        frame_start = 1'b1;
        wr(1'b1, 8'h19);
        frame_start = 1'b0;
        check("r6_same_cycle", 64'(rq(6)), 64'h19);

        // Fill bits, out-of-range read, external write
        shadow_en = 1'b0;
        wr(1'b0, 8'd5);
        wr(1'b1, 8'h00);
        rd(1'b1);
        check("r5_fill", 64'(db_out), 64'hE0);
        wr(1'b0, 8'd50);
        rd(1'b1);
        check("sel50_read", 64'(db_out), 64'hFF);
        wr(1'b0, 8'd19);
        wr(1'b1, 8'h3C);
        check("ext_wr_pulse", 64'(ext_wr), 64'h1);
        check("ext_sel", 64'(ext_sel), 64'd19);
        tick();
        check("ext_wr_one_cycle", 64'(ext_wr), 64'h0);
        check("r19_untouched", 64'(rq(19)), 64'h0);
        rd(1'b1);
        check("ext_read", 64'(db_out), 64'hA5);

        // Read-only and version-gated registers
        wr(1'b0, 8'd16);
        wr(1'b1, 8'hAA);
        check("r16_readonly", 64'(rq(16)), 64'h0);
        wr(1'b0, 8'd37);
        wr(1'b1, 8'h11);
        check("r37_blocked", 64'(rq(37)), 64'h0);
        rd(1'b1);
        check("r37_blocked_read", 64'(db_out), 64'h80);
        version = 2'd2;
        wr(1'b1, 8'h11);
        check("r37_written", 64'(rq(37)), 64'h11);
        rd(1'b1);
        check("r37_read", 64'(db_out), 64'h91);

        // Light pen capture, second strobe ignored
        lp_v = 8'h12; lp_h = 8'h34; lp_strobe = 1'b1; tick();
        lp_v = 8'h55; lp_h = 8'h66; tick();
        lp_strobe = 1'b0;
        check("lp_r16", 64'(rq(16)), 64'h12);
        check("lp_r17", 64'(rq(17)), 64'h34);
        rd(1'b0);
        check("status_lp_set", 64'(db_out), 64'hE2);
        rd(1'b0);
        check("status_lp_clear", 64'(db_out), 64'hA2);
        wr(1'b0, 8'd16);
        rd(1'b1);
        check("r16_data_read", 64'(db_out), 64'h12);

        // Strobe coinciding with status read wins
        lp_v = 8'h21; lp_h = 8'h43; lp_strobe = 1'b1;
        rd(1'b0);
        lp_strobe = 1'b0;
        check("coinc_status", 64'(db_out), 64'hA2);
        check("coinc_r16", 64'(rq(16)), 64'h21);
        rd(1'b0);
        check("coinc_status_after", 64'(db_out), 64'hE2);

        // Pending flush when shadow_en drops
        shadow_en = 1'b1;
        wr(1'b0, 8'd3);
        wr(1'b1, 8'h44);
        check("r3_pending", 64'(rq(3)), 64'h0);
        shadow_en = 1'b0;
        tick();
        check("r3_flushed", 64'(rq(3)), 64'h44);

        // Reset discards pending update
        shadow_en = 1'b1;
        wr(1'b0, 8'd2);
        wr(1'b1, 8'h99);
        check("r2_pending", 64'(rq(2)), 64'h0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("r2_after_reset", 64'(rq(2)), 64'h0);
        check("db_out_after_reset", 64'(db_out), 64'h0);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("r2_after_frame", 64'(rq(2)), 64'h0);

        // No state change without enableBus
        shadow_en = 1'b0;
        wr(1'b0, 8'd1);
        wr(1'b1, 8'h55);
        check("r1_rewrite", 64'(rq(1)), 64'h55);
        bus(1'b0, 1'b1, 1'b1, 8'h66);
        check("r1_no_enable", 64'(rq(1)), 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
